// File: rtl/dmem_pkg.sv
// dmem_pkg: shared depth default, clear-sequencer state encoding and requester ids
package dmem_pkg;
  localparam int DEPTH_DEF = 64;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: one requester port (valid/we/addr/wdata -> ready, rsp_valid/rsp_rdata/rsp_err); master=requester, slave=arbiter
interface dmem_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic valid;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic ready;
  logic rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic rsp_err;
  modport master (output valid, we, addr, wdata, input ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave (input valid, we, addr, wdata, output ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_clear_seq.sv
// dmem_clear_seq: on start walks addr 0..DEPTH-1 one per cycle with busy high (clk, reset, start -> busy, addr)
module dmem_clear_seq
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] addr
);
  clr_state_t state;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      addr <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= CLEAR;
        busy <= 1'b1;
        addr <= '0;
      end
    end else if (addr == AW'(DEPTH - 1)) begin
      state <= IDLE;
      busy <= 1'b0;
    end else begin
      addr <= addr + 1'b1;
    end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data-memory port between cpu and dma requesters (CPU priority, starvation guard) plus a zeroing clear sequencer (clk, reset, cpu/dma ports, clr_start/clr_busy, mem_*)
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = DEPTH_DEF,
  parameter int STARVE_LIMIT = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  dmem_port_arbiter_if.slave cpu,
  dmem_port_arbiter_if.slave dma,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  logic [AW-1:0] clr_addr;
  logic [SW-1:0] starve;
  logic idle, clearing, cpu_gnt, dma_gnt, sel, sel_we, ok;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  dmem_clear_seq #(.DEPTH(DEPTH)) u_clr (
    .clk(clk),
    .reset(reset),
    .start(clr_start),
    .busy(clr_busy),
    .addr(clr_addr)
  );
  always_comb begin
    idle = !reset && !clr_busy && !clr_start;
    clearing = clr_busy && !reset;
    dma_gnt = idle && dma.valid && (!cpu.valid || starve == SW'(STARVE_LIMIT));
    cpu_gnt = idle && cpu.valid && !dma_gnt;
    sel = dma_gnt ? REQ_DMA : REQ_CPU;
    sel_we = sel == REQ_DMA ? dma.we : cpu.we;
    sel_addr = sel == REQ_DMA ? dma.addr : cpu.addr;
    sel_wdata = sel == REQ_DMA ? dma.wdata : cpu.wdata;
    ok = (cpu_gnt || dma_gnt) && sel_addr < ADDR_W'(DEPTH);
    cpu.ready = cpu_gnt;
    dma.ready = dma_gnt;
    mem_read = ok && !sel_we;
    mem_write = clearing || (ok && sel_we);
    mem_addr = clearing ? ADDR_W'(clr_addr) : ok ? sel_addr : '0;
    mem_wdata = ok ? sel_wdata : '0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      starve <= '0;
      cpu.rsp_valid <= 1'b0;
      cpu.rsp_err <= 1'b0;
      cpu.rsp_rdata <= '0;
      dma.rsp_valid <= 1'b0;
      dma.rsp_err <= 1'b0;
      dma.rsp_rdata <= '0;
    end else begin
      starve <= !dma.valid || dma_gnt ? '0 : cpu_gnt && starve != SW'(STARVE_LIMIT) ? starve + 1'b1 : starve;
      cpu.rsp_valid <= cpu_gnt;
      cpu.rsp_err <= cpu_gnt && !ok;
      cpu.rsp_rdata <= cpu_gnt && mem_read ? mem_rdata : '0;
      dma.rsp_valid <= dma_gnt;
      dma.rsp_err <= dma_gnt && !ok;
      dma.rsp_rdata <= dma_gnt && mem_read ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed self-checking bench for dmem_port_arbiter with a 64-word memory model
module tb_dmem_port_arbiter;
  logic clk, reset, clr_start, clr_busy, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64];
  int tests = 0;
  int fails = 0;
  dmem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) cpu_if ();
  dmem_port_arbiter_if #(.DATA_W(32), .ADDR_W(32)) dma_if ();
  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .STARVE_LIMIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .cpu(cpu_if),
    .dma(dma_if),
    .clr_start(clr_start),
    .clr_busy(clr_busy),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_write && mem_addr < 64) mem[mem_addr[5:0]] <= mem_wdata;
  assign mem_rdata = mem_addr < 64 ? mem[mem_addr[5:0]] : 32'h0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic dma_op(input logic we, input int a, input logic [31:0] d);
    dma_if.valid = 1'b1;
    dma_if.we = we;
    dma_if.addr = 32'(a);
    dma_if.wdata = d;
    #3;
    chk($sformatf("dma_ready@%0d", a), {95'd0, dma_if.ready}, 96'd1);
    tick();
    dma_if.valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    clr_start = 1'b0;
    cpu_if.valid = 1'b1;
    cpu_if.we = 1'b0;
    cpu_if.addr = 32'd0;
    cpu_if.wdata = 32'd0;
    dma_if.valid = 1'b0;
    dma_if.we = 1'b0;
    dma_if.addr = 32'd0;
    dma_if.wdata = 32'd0;
    tick();
    tick();
    #3;
    chk("reset_ready", {94'd0, cpu_if.ready, mem_read}, 96'd0);
    reset = 1'b0;
    cpu_if.valid = 1'b0;
    tick();
    chk("reset_state", {91'd0, cpu_if.rsp_valid, dma_if.rsp_valid, clr_busy, mem_write, mem_read}, 96'd0);
    chk("reset_addr", {32'd0, mem_addr, mem_wdata}, 96'd0);
    // 1: CPU write then read back
    cpu_if.valid = 1'b1;
    cpu_if.we = 1'b1;
    cpu_if.addr = 32'd5;
    cpu_if.wdata = 32'hDEADBEEF;
    #3;
    chk("t1_wr_bus", {29'd0, cpu_if.ready, mem_write, mem_read, mem_addr, mem_wdata}, {29'd0, 3'b110, 32'd5, 32'hDEADBEEF});
    tick();
    chk("t1_wr_rsp", {62'd0, cpu_if.rsp_valid, cpu_if.rsp_err, cpu_if.rsp_rdata}, {62'd0, 2'b10, 32'd0});
    cpu_if.we = 1'b0;
    #3;
    chk("t1_rd_bus", {61'd0, cpu_if.ready, mem_write, mem_read, mem_addr}, {61'd0, 3'b101, 32'd5});
    tick();
    cpu_if.valid = 1'b0;
    chk("t1_rd_rsp", {62'd0, cpu_if.rsp_valid, cpu_if.rsp_err, cpu_if.rsp_rdata}, {62'd0, 2'b10, 32'hDEADBEEF});
    // 2: both valid continuously -> C,C,C,C,D
    cpu_if.valid = 1'b1;
    cpu_if.addr = 32'd5;
    dma_if.valid = 1'b1;
    dma_if.we = 1'b0;
    dma_if.addr = 32'd6;
    for (int k = 0; k < 10; k++) begin
      #3;
      chk($sformatf("t2_grant[%0d]", k), {94'd0, cpu_if.ready, dma_if.ready}, {94'd0, (k % 5 == 4) ? 2'b01 : 2'b10});
      tick();
    end
    cpu_if.valid = 1'b0;
    dma_if.valid = 1'b0;
    tick();
    // 3: out-of-range DMA read
    dma_if.valid = 1'b1;
    dma_if.addr = 32'd64;
    #3;
    chk("t3_bus", {93'd0, dma_if.ready, mem_read, mem_write}, {93'd0, 3'b100});
    tick();
    dma_if.valid = 1'b0;
    chk("t3_rsp", {62'd0, dma_if.rsp_valid, dma_if.rsp_err, dma_if.rsp_rdata}, {62'd0, 2'b11, 32'd0});
    // 4+5: fill, clear with a CPU request pending from the clr_start cycle
    for (int i = 0; i < 64; i++) dma_op(1'b1, i, 32'(i + 100));
    dma_op(1'b0, 7, 32'd0);
    chk("t4_prefill", {64'd0, dma_if.rsp_rdata}, 96'd107);
    cpu_if.valid = 1'b1;
    cpu_if.we = 1'b0;
    cpu_if.addr = 32'd7;
    clr_start = 1'b1;
    #3;
    chk("t5_start_cycle", {94'd0, cpu_if.ready, mem_write}, 96'd0);
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      #3;
      chk($sformatf("t4_clr[%0d]", i), {29'd0, clr_busy, mem_write, cpu_if.ready, mem_addr, mem_wdata}, {29'd0, 3'b110, 32'(i), 32'd0});
      tick();
    end
    #3;
    chk("t5_after_clear", {94'd0, clr_busy, cpu_if.ready}, 96'd1);
    tick();
    cpu_if.valid = 1'b0;
    chk("t5_rsp", {63'd0, cpu_if.rsp_valid, cpu_if.rsp_rdata}, {63'd1, 32'd0});
    for (int i = 0; i < 64; i++) begin
      dma_op(1'b0, i, 32'd0);
      chk($sformatf("t4_zero[%0d]", i), {64'd0, dma_if.rsp_rdata}, 96'd0);
    end
    // 6: reset while clearing address 20
    for (int i = 0; i < 64; i++) dma_op(1'b1, i, 32'(i + 200));
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("t6_at20", {63'd0, mem_write, mem_addr}, {63'd1, 32'd20});
    reset = 1'b1;
    #2;
    chk("t6_rst_cycle", {95'd0, mem_write}, 96'd0);
    tick();
    reset = 1'b0;
    #2;
    chk("t6_after_rst", {94'd0, clr_busy, mem_write}, 96'd0);
    tick();
    for (int i = 0; i < 64; i++) begin
      dma_op(1'b0, i, 32'd0);
      chk($sformatf("t6_word[%0d]", i), {64'd0, dma_if.rsp_rdata}, {64'd0, i < 20 ? 32'd0 : 32'(i + 200)});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
